// File: rtl/bcd_to_bin.sv
// Three-digit BCD to 8-bit binary converter using a sequential reverse double-dabble.
// One conversion takes a fixed 10 SHIFT cycles; results saturate at 255 and flag invalid digits.
`timescale 1ns/1ps

module bcd_to_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] bin_out,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_STEP = 4'd9;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  acc_q, acc_d;
  logic        bad_q, bad_d;
  logic [7:0]  bin_q, bin_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic [11:0] bcd_step;
  logic [9:0]  acc_step;

  // Halve the BCD number: shift right, then a digit that received a carried-in
  // 8 (i.e. value >= 8) is really "10/2 = 5" too large by 3.
  function automatic logic [3:0] fix_digit(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  always_comb begin
    logic [21:0] shifted;
    shifted  = {bcd_q, acc_q} >> 1;
    acc_step = shifted[9:0];
    bcd_step = {fix_digit(shifted[21:18]),
                fix_digit(shifted[17:14]),
                fix_digit(shifted[13:10])};
  end

  // NOTE: every combinational output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          bcd_d   = {hundreds, tens, ones};
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
        end
      end

      S_SHIFT: begin
        bcd_d = bcd_step;
        acc_d = acc_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          cnt_d   = '0;
          // The result is taken from the accumulator after this final step.
          if (bad_q) begin
            bin_d = '0;
            ovf_d = 1'b0;
            err_d = 1'b1;
          end else if (acc_step > 10'd255) begin
            bin_d = 8'hFF;
            ovf_d = 1'b1;
            err_d = 1'b0;
          end else begin
            bin_d = acc_step[7:0];
            ovf_d = 1'b0;
            err_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      acc_q   <= '0;
      bad_q   <= 1'b0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Status decodes straight from the state flop, so reset clears them at once.
  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign bin_out = bin_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: hand-computed vectors, latency/handshake checks,
// mid-conversion reset, held start, and a full 000-999 sweep with random gaps.
`timescale 1ns/1ps

module tb_bcd_to_bin;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] bin_out;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       err;

  int vectors;
  int miscompares;

  bcd_to_bin dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin_out  (bin_out),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at the negedge right after the accept edge. Returns the number of
  // edges until done was seen (bounded) and how many cycles busy was high.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 30) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  // Full conversion: drive at a negedge, accept on the next posedge, check result.
  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic [7:0] exp_bin, input logic exp_ovf, input logic exp_err,
                         input string tag, input bit full_checks);
    int edges;
    int bcyc;
    hundreds = h;
    tens     = t;
    ones     = o;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, bcyc);
    check({tag, " latency"}, edges, 10);
    check({tag, " bin_out"}, bin_out, exp_bin);
    check({tag, " ovf"}, ovf, exp_ovf);
    check({tag, " err"}, err, exp_err);
    if (full_checks) begin
      check({tag, " busy cycles"}, bcyc, 10);
      check({tag, " busy low in done"}, busy, 0);
    end
    @(negedge clk);
    if (full_checks) check({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    int edges;
    int bcyc;
    int gap;
    int v;
    int exp_v;
    logic [7:0] held_bin;
    bit saw_done;

    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    start    = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;

    // Start asserted during reset must not be accepted.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bin_out", bin_out, 0);
    check("reset ovf", ovf, 0);
    check("reset err", err, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    convert(4'd1, 4'd2, 4'd3, 8'd123, 1'b0, 1'b0, "d123", 1'b1);
    convert(4'd2, 4'd5, 4'd5, 8'd255, 1'b0, 1'b0, "d255", 1'b1);
    convert(4'd2, 4'd5, 4'd6, 8'd255, 1'b1, 1'b0, "d256", 1'b1);
    convert(4'd0, 4'd0, 4'd0, 8'd0,   1'b0, 1'b0, "d000", 1'b1);
    convert(4'd9, 4'd9, 4'd9, 8'd255, 1'b1, 1'b0, "d999", 1'b1);
    convert(4'd0, 4'hA, 4'd3, 8'd0,   1'b0, 1'b1, "bad_tens", 1'b1);
    convert(4'd0, 4'd0, 4'd1, 8'd1,   1'b0, 1'b0, "d001", 1'b0);
    convert(4'd1, 4'd2, 4'hF, 8'd0,   1'b0, 1'b1, "bad_ones", 1'b0);

    // Held start with digits changed mid-flight: result uses captured 0,4,2,
    // outputs hold during SHIFT, and the still-high start re-arms after DONE.
    convert(4'd0, 4'd1, 4'd7, 8'd17, 1'b0, 1'b0, "d017", 1'b0);
    hundreds = 4'd0;
    tens     = 4'd4;
    ones     = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    hundreds = 4'd9;
    tens     = 4'd9;
    ones     = 4'd9;
    repeat (3) @(negedge clk);
    check("hold bin_out during shift", bin_out, 17);
    check("hold busy during shift", busy, 1);
    wait_done(edges, bcyc);
    edges = edges + 3;
    check("held latency", edges, 10);
    check("held bin_out", bin_out, 42);
    check("held ovf", ovf, 0);
    @(negedge clk);
    check("held idle after done", {busy, done}, 2'b00);
    @(negedge clk);
    check("held restart busy", busy, 1);
    start = 1'b0;
    wait_done(edges, bcyc);
    check("restart latency", edges, 10);
    check("restart bin_out", bin_out, 255);
    check("restart ovf", ovf, 1);
    @(negedge clk);

    // Reset in the middle of a conversion abandons it with no done pulse.
    hundreds = 4'd1;
    tens     = 4'd2;
    ones     = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst bin_out", bin_out, 0);
    check("midrst ovf", ovf, 0);
    check("midrst err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("midrst no done", saw_done, 0);
    convert(4'd0, 4'd0, 4'd7, 8'd7, 1'b0, 1'b0, "after_rst", 1'b1);

    // Every valid BCD value, with random idle gaps between requests.
    held_bin = bin_out;
    for (int h = 0; h < 10; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 10; o++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge clk);
          v     = h * 100 + t * 10 + o;
          exp_v = (v > 255) ? 255 : v;
          convert(4'(h), 4'(t), 4'(o), 8'(exp_v), (v > 255), 1'b0, "sweep", 1'b0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the bench always terminates on its own.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
